// File: rtl/c_join3_sync.sv
// c_join3_sync: 3-way join; latches one token per branch and fires one merged token when all three are held.
// Ports: i_clk/i_rst (async, active-high); i_driveK/i_dataK branch tokens in; o_freeK branch consumed pulses;
// o_driveNext/o_data merged token out (data held while slot full); i_freeNext downstream consumed;
// o_busy slot full; o_err_ovf sticky drive-on-full-branch; o_tok_cnt merged tokens fired (wraps).
// Optional macro C_JOIN3_TIMEOUT_EN adds o_err_to, sticky after TO_CYC cycles stuck on a partial set.
module c_join3_sync #(
  parameter int DW = 8,
  parameter int CW = 16,
  parameter int TO_CYC = 255
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_drive0,
  input  logic          i_drive1,
  input  logic          i_drive2,
  input  logic [DW-1:0] i_data0,
  input  logic [DW-1:0] i_data1,
  input  logic [DW-1:0] i_data2,
  output logic          o_free0,
  output logic          o_free1,
  output logic          o_free2,
  output logic          o_driveNext,
  output logic [3*DW-1:0] o_data,
  input  logic          i_freeNext,
  output logic          o_busy,
  output logic          o_err_ovf,
`ifdef C_JOIN3_TIMEOUT_EN
  output logic          o_err_to,
`endif
  output logic [CW-1:0] o_tok_cnt
);
  typedef enum logic [1:0] {COLLECT, FIRE, HOLD} stateT;
  stateT state, stateNext;
  logic [2:0] flags, flagsNext, drive, accept;
  logic [DW-1:0] inData [3];
  logic [DW-1:0] held [3];
  logic [3*DW-1:0] outData;
  logic [CW-1:0] tokCnt;
  logic errOvf, firing;
  if (TO_CYC < 1) begin : gToCheck
    $error("TO_CYC must be at least 1");
  end
  assign drive = {i_drive2, i_drive1, i_drive0};
  assign inData[0] = i_data0;
  assign inData[1] = i_data1;
  assign inData[2] = i_data2;
  assign firing = state == FIRE;
  // Flags clear on the edge leaving FIRE, so a drive in that cycle lands in an empty slot.
  assign accept = drive & (firing ? 3'b111 : ~flags);
  assign flagsNext = firing ? drive : (flags | drive);
  always_comb begin
    stateNext = state;
    case (state)
      COLLECT: stateNext = &flags ? FIRE : COLLECT;
      FIRE:    stateNext = HOLD;
      HOLD:    stateNext = i_freeNext ? COLLECT : HOLD;
      default: stateNext = COLLECT;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= COLLECT;
      flags <= '0;
      outData <= '0;
      tokCnt <= '0;
      errOvf <= 1'b0;
    end else begin
      state <= stateNext;
      flags <= flagsNext;
      if (stateNext == FIRE) outData <= {held[2], held[1], held[0]};
      if (firing) tokCnt <= tokCnt + 1'b1;
      if (|(drive & flags) && !firing) errOvf <= 1'b1;
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < 3; k++) held[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) if (accept[k]) held[k] <= inData[k];
    end
  end
`ifdef C_JOIN3_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] toCnt;
  logic errTo, partial;
  assign partial = state == COLLECT && |flags && !(&flags);
  // Counts consecutive cycles a partial set sits unchanged; any flag change restarts it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      toCnt <= '0;
      errTo <= 1'b0;
    end else if (!partial || flagsNext != flags) begin
      toCnt <= '0;
    end else if (toCnt != TW'(TO_CYC)) begin
      toCnt <= toCnt + 1'b1;
      if (toCnt == TW'(TO_CYC - 1)) errTo <= 1'b1;
    end
  end
  assign o_err_to = errTo;
`endif
  assign o_free0 = firing;
  assign o_free1 = firing;
  assign o_free2 = firing;
  assign o_driveNext = firing;
  assign o_busy = state != COLLECT;
  assign o_data = outData;
  assign o_err_ovf = errOvf;
  assign o_tok_cnt = tokCnt;
endmodule

// File: doc/c_join3_sync.md
Name: c_join3_sync

Overview:
- Clocked 3-way join stage. It sits directly downstream of the 3-way copy fork and consumes the three copied branches.
- Each branch carries a drive/free handshake plus data. The block latches one token per branch and fires a single merged token once all three branches hold one.
- It returns free to each branch when it consumes the set, and holds the merged token until the next stage frees it.
- It rebuilds the single-token view of the pipeline that the fork split apart.

Parameters:
- DW, 8, data width per branch.
- CW, 16, width of the merged-token counter.
- TO_CYC, 255, timeout threshold in cycles; used only with the optional feature.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_drive0/1/2  in  1 each  branch token-valid, one-cycle pulse.
- i_data0/1/2  in  DW each  branch data, sampled when the matching drive is high.
- o_free0/1/2  out  1 each  branch token consumed, one-cycle pulse.
- o_driveNext  out  1  merged token valid, one-cycle pulse.
- o_data  out  3*DW  merged data {data2,data1,data0}; held while the output slot is full.
- i_freeNext  in  1  downstream consumed the merged token, one-cycle pulse.
- o_busy  out  1  high while the output slot is full.
- o_err_ovf  out  1  sticky overflow error flag.
- o_tok_cnt  out  CW  count of merged tokens fired; wraps modulo 2^CW.

Behaviour:
- Reset (async, active-high). While i_rst=1, and at release:
  - All branch flags, output slot and error cleared; o_tok_cnt=0.
  - o_free0/1/2, o_driveNext, o_busy, o_err_ovf = 0; o_data=0.
  - Reset mid-operation discards partial and pending tokens; no free pulses are emitted for them.
- Per-branch capture:
  - A branch with flag k=0 and i_drivek=1 at an edge sets flag k and latches i_datak.
  - Drive on a branch whose flag is already set (and is not being cleared this edge) sets o_err_ovf. The new token is dropped and the held data is unchanged.
- State machine: COLLECT, FIRE, HOLD.
  - COLLECT: wait for all three flags set. Move to FIRE when all three flags are set and the slot is empty. Flags may arrive in any order or simultaneously.
  - FIRE: lasts one cycle. o_driveNext=1 and o_free0=o_free1=o_free2=1 in this cycle.
    - o_data is loaded at the edge entering FIRE and is stable during the pulse.
    - All flags clear at the edge leaving FIRE; o_tok_cnt increments at that edge.
    - A drive arriving in the FIRE cycle is accepted into the freshly cleared flag, with no overflow.
    - Next state is HOLD.
  - HOLD: o_busy=1, o_data held. Branch flags keep collecting the next set.
    - i_freeNext=1 at an edge returns the state to COLLECT. The next fire can come no earlier than the following cycle.
    - i_freeNext outside HOLD is ignored.
- Latency: third flag captured at edge n → o_driveNext high in cycle n+1 (the edge n+1 transition makes it visible). This is 1 cycle when the slot is empty.
- Throughput: at most one merged token per 3 cycles (FIRE → HOLD → COLLECT).
- o_tok_cnt wraps from 2^CW−1 to 0 with no flag.

Optional Feature:
- Macro: C_JOIN3_TIMEOUT_EN.
- Enabled:
  - A timeout counter runs while in COLLECT with at least one but not all flags set. It resets whenever the flag set changes or a fire occurs.
  - On reaching TO_CYC the output o_err_to goes high, sticky until reset. Flags are kept, not flushed.
- Disabled: no counter and no o_err_to port. Behaviour is otherwise identical.

Test Plan:
- Reset mid-HOLD with o_data=0x030201 → all outputs 0 after i_rst; no o_free pulse; o_tok_cnt=0.
- Simultaneous drives, data 0x11/0x22/0x33, slot empty → o_driveNext pulse one cycle later; o_data=0x332211; all three o_free pulse in the same cycle; o_tok_cnt=1.
- Staggered arrivals: branch0 at cycle 0, branch2 at cycle 3, branch1 at cycle 7 → fire in cycle 8; no earlier o_driveNext.
- Second drive on branch1 while its flag is set → o_err_ovf=1 sticky; the merged data keeps the first branch1 value.
- Full set collected during HOLD, i_freeNext at cycle 10 → next o_driveNext in cycle 11; a drive in a FIRE cycle is accepted with no error.
- With C_JOIN3_TIMEOUT_EN and TO_CYC=5: only branch0 driven → o_err_to=1 after 5 cycles; completing the set still fires normally.
